comparador_serial: RTL
======================

# comparador_serial

- Sequential, parametrised magnitude comparator for two N-bit unsigned words.
- Processes K bits per clock, either left-to-right (MSB first) or right-to-left (LSB first), and reports A>B, A<B or A==B with a start/busy/done handshake.
- Successor to the combinational iterative comparator network: the per-bit typical cell becomes a registered K-bit stage reused over N/K cycles.
- Sits between the operand registers and the result consumer in the comparison datapath.

## Interface
Parameters:
- N, 8, operand width in bits; N ≥ 2.
- K, 1, bits processed per cycle; 1 ≤ K ≤ N and N % K == 0, else elaboration must fail.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- A  in  N  operand A, unsigned.
- B  in  N  operand B, unsigned.
- dir  in  1  scan direction, captured with start: 0 = left-to-right (MSB first), 1 = right-to-left (LSB first).
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse when results update.
- mayor  out  1  A > B.
- menor  out  1  A < B.
- igual  out  1  A == B.

## Operation
- State variables (p,q): 01 = equal (initial state), 10 = A>B, 00 = A<B; 11 is unreachable and, if forced, is treated as 01.
- FSM states and transitions:
  - IDLE: when start=1, capture A, B and dir into shift registers, load (p,q)=01, clear the group counter, go to RUN.
  - RUN: each cycle consume one K-bit group, update (p,q), increment the counter. After group N/K-1 is consumed, load mayor/menor/igual from (p,q), pulse done, return to IDLE.
- Left-to-right (dir=0):
  - Groups are consumed from bits [N-1:N-K] downward.
  - Once (p,q) ≠ 01 it is frozen.
  - Within a group, the most significant differing bit decides.
- Right-to-left (dir=1):
  - Groups are consumed from bits [K-1:0] upward.
  - A group containing any differing bit overwrites (p,q) with the decision of its most significant differing bit.
  - An all-equal group leaves (p,q) unchanged.
- Exactly one of mayor/menor/igual is high after the first done; all three are 0 before it.
- Results hold until the next done.
- start while busy=1 is ignored. A, B and dir changes after capture have no effect.
- Reset mid-operation: the FSM returns to IDLE, the comparison is abandoned, no done is issued, and all outputs go to 0.

## Timing
- Reset values: busy=0, done=0, mayor=0, menor=0, igual=0; FSM in IDLE.
- Edge e0 samples start=1: busy=1 after e0.
- Edges e1..e(N/K) each consume one group.
- After edge e(N/K): results valid, done=1, busy=0. Latency is N/K cycles from e0.
- done is low again after the next edge.
- start may be high during the done cycle and is accepted at that edge (back-to-back throughput: one comparison per N/K+1 cycles).
- busy and done are never high together.

## Configuration
- COMPARADOR_SALIDA_TEMPRANA_EN defined:
  - With dir=0 only: if the group consumed at edge ej (j < N/K) leaves (p,q) ≠ 01, results load and done pulses after ej, and busy drops.
  - Latency is j cycles.
  - dir=1 is unaffected.
- Not defined: latency is always N/K cycles; early-exit logic is absent.

## Test plan
- N=8,K=1,dir=0, A=0xA5, B=0xA5 → igual=1 with done 8 cycles after start; mayor=menor=0.
- N=8,K=1,dir=0, A=0x80, B=0x7F → mayor=1. Done after 8 cycles without the macro, 1 cycle with COMPARADOR_SALIDA_TEMPRANA_EN.
- N=8,K=1,dir=1, A=0x01, B=0x02 → menor=1 after 8 cycles. The LSB group first gives mayor internally; bit 1 overrides it.
- N=8,K=4,dir=0, A=0x3C, B=0x3D → menor=1, done 2 cycles after start.
- Start A=0xFF, B=0x00; pulse start again at cycle 2 with A=0x00, B=0xFF → second start ignored, mayor=1. A new start in the done cycle is accepted; the second result is menor=1.
- Assert rst_n=0 at cycle 3 of a comparison → busy/done/results go to 0 immediately. No done follows. The next start runs normally.

Source files
------------

// File: rtl/comparador_serial.sv
// comparador_serial: sequential magnitude comparator for two N-bit unsigned
// words, consuming K bits per clock in either scan direction.
//
// Parameters: N (operand width, >= 2), K (bits per cycle, divides N).
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request, sampled only while idle
//   A, B              unsigned operands, captured with start
//   dir               0 = MSB first, 1 = LSB first, captured with start
//   busy              comparison in progress
//   done              one-cycle pulse when mayor/menor/igual update
//   mayor/menor/igual A>B / A<B / A==B, held until the next done
//
// Optional feature: define COMPARADOR_SALIDA_TEMPRANA_EN to finish an
// MSB-first scan as soon as the result is decided.
module comparador_serial #(
   parameter int unsigned N = 8,
   parameter int unsigned K = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         dir,
   output logic         busy,
   output logic         done,
   output logic         mayor,
   output logic         menor,
   output logic         igual
);

   // Reject illegal parameter combinations at elaboration.
   if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
      $error("comparador_serial: illegal N=%0d K=%0d", N, K);
   end

   localparam int unsigned G  = N / K;
   localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;

   // (p,q) encoding of the running decision.
   localparam logic [1:0] PQ_EQ = 2'b01;
   localparam logic [1:0] PQ_GT = 2'b10;
   localparam logic [1:0] PQ_LT = 2'b00;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    sa, sa_nxt, sb, sb_nxt;
   logic            dir_r, dir_nxt;
   logic [1:0]      pq, pq_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            busy_nxt, done_nxt, mayor_nxt, menor_nxt, igual_nxt;

   logic [K-1:0]    ga, gb;
   logic            found, gt;
   logic [1:0]      pq_eff, pq_upd;
   logic            last, early, finish;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         dir_r <= 1'b0;
         pq    <= PQ_EQ;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         mayor <= 1'b0;
         menor <= 1'b0;
         igual <= 1'b0;
      end else begin
         state <= state_nxt;
         sa    <= sa_nxt;
         sb    <= sb_nxt;
         dir_r <= dir_nxt;
         pq    <= pq_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         mayor <= mayor_nxt;
         menor <= menor_nxt;
         igual <= igual_nxt;
      end
   end

   // Next-state, group evaluation and output logic.
   always_comb begin
      state_nxt = state;
      sa_nxt    = sa;
      sb_nxt    = sb;
      dir_nxt   = dir_r;
      pq_nxt    = pq;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      mayor_nxt = mayor;
      menor_nxt = menor;
      igual_nxt = igual;
      found     = 1'b0;
      gt        = 1'b0;

      // Current group sits at the end of the shift registers the scan starts from.
      ga = dir_r ? sa[K-1:0] : sa[N-1 -: K];
      gb = dir_r ? sb[K-1:0] : sb[N-1 -: K];

      // Ascending scan: the last hit is the most significant differing bit.
      for (int i = 0; i < int'(K); i++) begin
         if (ga[i] != gb[i]) begin
            found = 1'b1;
            gt    = ga[i];
         end
      end

      pq_eff = (pq == 2'b11) ? PQ_EQ : pq;
      if (found && (dir_r || pq_eff == PQ_EQ))
         pq_upd = gt ? PQ_GT : PQ_LT;
      else
         pq_upd = pq_eff;

      last = (cnt == CW'(G - 1));
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
      early = !dir_r && (pq_upd != PQ_EQ);
`else
      early = 1'b0;
`endif
      finish = last || early;

      case (state)
         IDLE: begin
            if (start) begin
               sa_nxt    = A;
               sb_nxt    = B;
               dir_nxt   = dir;
               pq_nxt    = PQ_EQ;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            pq_nxt  = pq_upd;
            cnt_nxt = cnt + CW'(1);
            sa_nxt  = dir_r ? (sa >> K) : (sa << K);
            sb_nxt  = dir_r ? (sb >> K) : (sb << K);
            if (finish) begin
               mayor_nxt = (pq_upd == PQ_GT);
               menor_nxt = (pq_upd == PQ_LT);
               igual_nxt = (pq_upd == PQ_EQ);
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
